// File: rtl/commit_mem_read_linefillbuffer.sv
// Purpose: circular line-fill buffer of returned read words (per-entry line tag, word offset, data) feeding commit-stage data update.
// Latency: push visible on doutb one cycle later (no fall-through); pop advances head at the sampling edge.
// Backpressure: push dropped when full without a same-cycle pop (sticky s_overflow); pop on empty ignored; flush wins over both.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   flush                  synchronous clear of entries, pointers, overflow and last-popped tag
//   wea, dina_addr/data    push request with byte address and data word
//   web                    pop request
//   doutb_addr/data        head entry {tag, offset, 2'b0} and data; zero when empty
//   doutb_newline          head tag differs from the last popped tag (or nothing popped yet)
//   s_full/s_empty/s_almost_full/s_count/s_overflow   registered status
module commit_mem_read_linefillbuffer #(
  parameter int DEPTH        = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_BITS  = 3,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         wea,
  input  logic [ADDR_WIDTH-1:0]        dina_addr,
  input  logic [DATA_WIDTH-1:0]        dina_data,
  input  logic                         web,
  output logic [ADDR_WIDTH-1:0]        doutb_addr,
  output logic [DATA_WIDTH-1:0]        doutb_data,
  output logic                         doutb_newline,
  output logic                         s_full,
  output logic                         s_empty,
  output logic                         s_almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   s_count,
  output logic                         s_overflow
);

  localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS - 2;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_THRESH);

  // Storage is intentionally not reset; validity is tracked by count_q alone.
  logic [TAG_W-1:0]       tag_mem_q  [DEPTH];
  logic [OFFSET_BITS-1:0] off_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0]  data_mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             last_valid_q, last_valid_d;
  logic [TAG_W-1:0] last_tag_q, last_tag_d;

  logic             pop_ok;
  logic             push_ok;
  logic [TAG_W-1:0] wr_tag;
  logic [OFFSET_BITS-1:0] wr_off;
  logic [TAG_W-1:0] head_tag;
  logic [OFFSET_BITS-1:0] head_off;
  logic [DATA_WIDTH-1:0]  head_data;

  // Byte-lane bits of the address carry no information for word returns.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^dina_addr[1:0];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_tag = dina_addr[ADDR_WIDTH-1:OFFSET_BITS+2];
  assign wr_off = dina_addr[OFFSET_BITS+1:2];

  // Status decoded purely from registers.
  assign s_empty       = (count_q == '0);
  assign s_full        = (count_q == CNT_FULL);
  assign s_almost_full = (count_q >= CNT_AFULL);
  assign s_count       = count_q;
  assign s_overflow    = overflow_q;

  // Pop is qualified by flush so a flush cycle never disturbs last-tag state.
  assign pop_ok  = web & ~s_empty & ~flush;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push_ok = wea & (~s_full | (web & ~s_empty)) & ~flush;

  assign head_tag  = tag_mem_q[rd_ptr_q];
  assign head_off  = off_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  always_comb begin
    doutb_addr    = '0;
    doutb_data    = '0;
    doutb_newline = 1'b0;
    if (!s_empty) begin
      doutb_addr    = {head_tag, head_off, 2'b00};
      doutb_data    = head_data;
      doutb_newline = ~last_valid_q | (head_tag != last_tag_q);
    end
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    last_valid_d = last_valid_q;
    last_tag_d   = last_tag_q;

    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      last_valid_d = 1'b0;
    end else begin
      if (pop_ok) begin
        rd_ptr_d     = ptr_inc(rd_ptr_q);
        last_tag_d   = head_tag;
        last_valid_d = 1'b1;
      end
      if (push_ok) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wea & s_full & ~web) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      last_valid_q <= 1'b0;
      last_tag_q   <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      last_valid_q <= last_valid_d;
      last_tag_q   <= last_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      tag_mem_q[wr_ptr_q]  <= wr_tag;
      off_mem_q[wr_ptr_q]  <= wr_off;
      data_mem_q[wr_ptr_q] <= dina_data;
    end
  end

endmodule

// File: tb/tb_commit_mem_read_linefillbuffer.sv
// Purpose: self-checking bench for the line-fill buffer at DEPTH=8 and DEPTH=5/AFULL=3.
// Latency: one clock per modelled cycle; inputs driven at negedge, outputs sampled at negedge.
// Backpressure: reference queue model decides accept/drop/overflow from the buffer's rules.
module tb_commit_mem_read_linefillbuffer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic        flush = 1'b0, wea = 1'b0, web = 1'b0;
  logic [31:0] dina_addr = '0, dina_data = '0;

  always #5 clk = ~clk;

  logic [31:0] a8, d8, a5, d5;
  logic        nl8, f8, e8, af8, ov8, nl5, f5, e5, af5, ov5;
  logic [3:0]  c8;
  logic [2:0]  c5;

  commit_mem_read_linefillbuffer #(.DEPTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .flush(flush & ~sel), .wea(wea & ~sel),
    .dina_addr(dina_addr), .dina_data(dina_data), .web(web & ~sel),
    .doutb_addr(a8), .doutb_data(d8), .doutb_newline(nl8),
    .s_full(f8), .s_empty(e8), .s_almost_full(af8), .s_count(c8), .s_overflow(ov8));

  commit_mem_read_linefillbuffer #(.DEPTH(5), .AFULL_THRESH(3)) dut5 (
    .clk(clk), .resetn(resetn), .flush(flush & sel), .wea(wea & sel),
    .dina_addr(dina_addr), .dina_data(dina_data), .web(web & sel),
    .doutb_addr(a5), .doutb_data(d5), .doutb_newline(nl5),
    .s_full(f5), .s_empty(e5), .s_almost_full(af5), .s_count(c5), .s_overflow(ov5));

  wire [31:0] o_addr  = sel ? a5 : a8;
  wire [31:0] o_data  = sel ? d5 : d8;
  wire        o_nl    = sel ? nl5 : nl8;
  wire        o_full  = sel ? f5 : f8;
  wire        o_empty = sel ? e5 : e8;
  wire        o_afull = sel ? af5 : af8;
  wire        o_ovf   = sel ? ov5 : ov8;
  wire [3:0]  o_count = sel ? {1'b0, c5} : c8;

  // Reference model: a plain queue of accepted words plus last-popped line tag.
  typedef struct packed {logic [31:0] a; logic [31:0] d;} ent_t;
  ent_t        q[$];
  logic        ovf_m = 1'b0, lv_m = 1'b0;
  logic [26:0] lt_m = '0;

  int          exp_count;
  logic [31:0] exp_addr, exp_data;
  logic        exp_nl;
  int          tests = 0, fails = 0;

  task automatic model_clear();
    q.delete();
    ovf_m = 1'b0;
    lv_m  = 1'b0;
  endtask

  task automatic update_exp();
    exp_count = q.size();
    exp_addr  = '0;
    exp_data  = '0;
    exp_nl    = 1'b0;
    if (q.size() > 0) begin
      exp_addr = q[0].a;
      exp_data = q[0].d;
      exp_nl   = !lv_m || (q[0].a[31:5] != lt_m);
    end
  endtask

  // One clock: drive at negedge, update model at the edge, return at next negedge.
  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic f);
    int   n, dep;
    logic pop_ok, push_ok;
    ent_t e;
    dep     = sel ? 5 : 8;
    n       = q.size();
    pop_ok  = r && (n > 0);
    push_ok = w && (n < dep || pop_ok) && !f;
    wea = w; dina_addr = a; dina_data = d; web = r; flush = f;
    @(posedge clk);
    if (f) begin
      model_clear();
    end else begin
      if (pop_ok) begin
        lt_m = q[0].a[31:5];
        lv_m = 1'b1;
        e = q.pop_front();
      end
      if (push_ok) begin
        e.a = a & 32'hFFFF_FFFC;
        e.d = d;
        q.push_back(e);
      end
      if (w && n == dep && !r) ovf_m = 1'b1;
    end
    @(negedge clk);
    wea = 1'b0; web = 1'b0; flush = 1'b0;
    update_exp();
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h4000_0000 | (32'($urandom_range(0, 2)) << 5) | ($urandom & 32'h1F);
  endfunction

  task automatic test_reset();
    #12;
    tests += 10;
    if (e8 !== 1'b1)   begin fails++; $display("FAIL reset_empty8 got %b want 1", e8); end
    if (f8 !== 1'b0)   begin fails++; $display("FAIL reset_full8 got %b want 0", f8); end
    if (af8 !== 1'b0)  begin fails++; $display("FAIL reset_afull8 got %b want 0", af8); end
    if (c8 !== 4'd0)   begin fails++; $display("FAIL reset_count8 got %0d want 0", c8); end
    if (ov8 !== 1'b0)  begin fails++; $display("FAIL reset_ovf8 got %b want 0", ov8); end
    if (a8 !== 32'h0)  begin fails++; $display("FAIL reset_addr8 got %h want 0", a8); end
    if (d8 !== 32'h0)  begin fails++; $display("FAIL reset_data8 got %h want 0", d8); end
    if (nl8 !== 1'b0)  begin fails++; $display("FAIL reset_nl8 got %b want 0", nl8); end
    if (e5 !== 1'b1)   begin fails++; $display("FAIL reset_empty5 got %b want 1", e5); end
    if (c5 !== 3'd0)   begin fails++; $display("FAIL reset_count5 got %0d want 0", c5); end
    @(negedge clk);
    resetn = 1'b1;
    model_clear();
    update_exp();
  endtask

  task automatic test_basic();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    logic        nls   [3];
    addrs = '{32'h1000_0004, 32'h1000_0008, 32'h2000_001C};
    datas = '{32'hA, 32'hB, 32'hC};
    nls   = '{1'b1, 1'b0, 1'b1};
    sel = 1'b0;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, addrs[i], datas[i], 0, 0);
      tests++;
      if (o_count !== 4'(i + 1)) begin fails++; $display("FAIL basic_push_count got %0d want %0d", o_count, i + 1); end
    end
    for (int i = 0; i < 3; i++) begin
      tests += 3;
      if (o_addr !== addrs[i]) begin fails++; $display("FAIL basic_addr%0d got %h want %h", i, o_addr, addrs[i]); end
      if (o_data !== datas[i]) begin fails++; $display("FAIL basic_data%0d got %h want %h", i, o_data, datas[i]); end
      if (o_nl !== nls[i])     begin fails++; $display("FAIL basic_nl%0d got %b want %b", i, o_nl, nls[i]); end
      cycle(0, 0, 0, 1, 0);
      tests++;
      if (o_count !== 4'(2 - i)) begin fails++; $display("FAIL basic_pop_count got %0d want %0d", o_count, 2 - i); end
    end
  endtask

  task automatic test_overflow();
    sel = 1'b0;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, rand_addr(), $urandom, 0, 0);
    tests += 2;
    if (o_full !== 1'b1)    begin fails++; $display("FAIL ovf_full got %b want 1", o_full); end
    if (o_count !== 4'd8)   begin fails++; $display("FAIL ovf_count got %0d want 8", o_count); end
    cycle(1, rand_addr(), $urandom, 0, 0);
    cycle(0, 0, 0, 0, 0);
    tests += 3;
    if (o_count !== 4'd8)   begin fails++; $display("FAIL ovf_count9 got %0d want 8", o_count); end
    if (o_ovf !== ovf_m)    begin fails++; $display("FAIL ovf_flag got %b want %b", o_ovf, ovf_m); end
    if (o_ovf !== 1'b1)     begin fails++; $display("FAIL ovf_sticky got %b want 1", o_ovf); end
    for (int i = 0; i < 8; i++) begin
      tests += 3;
      if (o_addr !== exp_addr) begin fails++; $display("FAIL ovf_pop_addr got %h want %h", o_addr, exp_addr); end
      if (o_data !== exp_data) begin fails++; $display("FAIL ovf_pop_data got %h want %h", o_data, exp_data); end
      if (o_nl !== exp_nl)     begin fails++; $display("FAIL ovf_pop_nl got %b want %b", o_nl, exp_nl); end
      cycle(0, 0, 0, 1, 0);
    end
    tests++;
    if (o_empty !== 1'b1) begin fails++; $display("FAIL ovf_drained got %b want 1", o_empty); end
  endtask

  task automatic test_full_push_pop();
    int drained;
    sel = 1'b0;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, rand_addr(), $urandom, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tests += 2;
      if (o_addr !== exp_addr) begin fails++; $display("FAIL fpp_addr got %h want %h", o_addr, exp_addr); end
      if (o_data !== exp_data) begin fails++; $display("FAIL fpp_data got %h want %h", o_data, exp_data); end
      cycle(1, rand_addr(), $urandom, 1, 0);
      tests += 2;
      if (o_count !== 4'd8) begin fails++; $display("FAIL fpp_count got %0d want 8", o_count); end
      if (o_ovf !== 1'b0)   begin fails++; $display("FAIL fpp_ovf got %b want 0", o_ovf); end
    end
    drained = 0;
    while (q.size() > 0 && drained < 20) begin
      tests += 3;
      if (o_addr !== exp_addr) begin fails++; $display("FAIL fpp_drain_addr got %h want %h", o_addr, exp_addr); end
      if (o_data !== exp_data) begin fails++; $display("FAIL fpp_drain_data got %h want %h", o_data, exp_data); end
      if (o_nl !== exp_nl)     begin fails++; $display("FAIL fpp_drain_nl got %b want %b", o_nl, exp_nl); end
      cycle(0, 0, 0, 1, 0);
      drained++;
    end
    tests++;
    if (o_empty !== 1'b1) begin fails++; $display("FAIL fpp_empty got %b want 1", o_empty); end
  endtask

  task automatic test_flush();
    sel = 1'b0;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cycle(1, rand_addr(), $urandom, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
    tests += 2;
    if (o_count !== 4'd4) begin fails++; $display("FAIL flush_pre_count got %0d want 4", o_count); end
    if (o_ovf !== 1'b1)   begin fails++; $display("FAIL flush_pre_ovf got %b want 1", o_ovf); end
    cycle(1, rand_addr(), $urandom, 0, 1);
    tests += 6;
    if (o_empty !== 1'b1)  begin fails++; $display("FAIL flush_empty got %b want 1", o_empty); end
    if (o_count !== 4'd0)  begin fails++; $display("FAIL flush_count got %0d want 0", o_count); end
    if (o_ovf !== 1'b0)    begin fails++; $display("FAIL flush_ovf got %b want 0", o_ovf); end
    if (o_addr !== 32'h0)  begin fails++; $display("FAIL flush_addr got %h want 0", o_addr); end
    if (o_data !== 32'h0)  begin fails++; $display("FAIL flush_data got %h want 0", o_data); end
    if (o_nl !== 1'b0)     begin fails++; $display("FAIL flush_nl got %b want 0", o_nl); end
    cycle(1, rand_addr(), $urandom, 0, 0);
    tests += 3;
    if (o_nl !== 1'b1)       begin fails++; $display("FAIL flush_next_nl got %b want 1", o_nl); end
    if (o_count !== 4'd1)    begin fails++; $display("FAIL flush_next_count got %0d want 1", o_count); end
    if (o_addr !== exp_addr) begin fails++; $display("FAIL flush_next_addr got %h want %h", o_addr, exp_addr); end
  endtask

  task automatic test_wrap();
    logic w, r;
    sel = 1'b1;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 60; i++) begin
      w = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      cycle(w, rand_addr(), $urandom, r, 0);
      tests += 8;
      if (o_count !== 4'(exp_count))        begin fails++; $display("FAIL wrap_count got %0d want %0d", o_count, exp_count); end
      if (o_afull !== (exp_count >= 3))     begin fails++; $display("FAIL wrap_afull got %b want %b", o_afull, exp_count >= 3); end
      if (o_full !== (exp_count == 5))      begin fails++; $display("FAIL wrap_full got %b want %b", o_full, exp_count == 5); end
      if (o_empty !== (exp_count == 0))     begin fails++; $display("FAIL wrap_empty got %b want %b", o_empty, exp_count == 0); end
      if (o_addr !== exp_addr)              begin fails++; $display("FAIL wrap_addr got %h want %h", o_addr, exp_addr); end
      if (o_data !== exp_data)              begin fails++; $display("FAIL wrap_data got %h want %h", o_data, exp_data); end
      if (o_nl !== exp_nl)                  begin fails++; $display("FAIL wrap_nl got %b want %b", o_nl, exp_nl); end
      if (o_ovf !== ovf_m)                  begin fails++; $display("FAIL wrap_ovf got %b want %b", o_ovf, ovf_m); end
    end
  endtask

  task automatic test_async_reset();
    sel = 1'b0;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, rand_addr(), $urandom, 0, 0);
    #2;
    resetn = 1'b0;
    #1;
    tests += 3;
    if (e8 !== 1'b1)  begin fails++; $display("FAIL arst_empty got %b want 1", e8); end
    if (c8 !== 4'd0)  begin fails++; $display("FAIL arst_count got %0d want 0", c8); end
    if (a8 !== 32'h0) begin fails++; $display("FAIL arst_addr got %h want 0", a8); end
    model_clear();
    update_exp();
    @(negedge clk);
    resetn = 1'b1;
    cycle(0, 0, 0, 1, 0);
    tests += 2;
    if (o_empty !== 1'b1) begin fails++; $display("FAIL arst_pop_empty got %b want 1", o_empty); end
    if (o_count !== 4'd0) begin fails++; $display("FAIL arst_pop_count got %0d want 0", o_count); end
    cycle(1, 32'h3000_0044, 32'h1234_5678, 0, 0);
    tests += 4;
    if (o_count !== 4'd1)         begin fails++; $display("FAIL arst_push_count got %0d want 1", o_count); end
    if (o_addr !== 32'h3000_0044) begin fails++; $display("FAIL arst_push_addr got %h want 30000044", o_addr); end
    if (o_data !== 32'h1234_5678) begin fails++; $display("FAIL arst_push_data got %h want 12345678", o_data); end
    if (o_nl !== 1'b1)            begin fails++; $display("FAIL arst_push_nl got %b want 1", o_nl); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
